// File: rtl/rx_align_pkg.sv
// rx_align_pkg: shared constants, counter widths and FSM states for the receive word aligner
package rx_align_pkg;
  localparam int W           = 10;
  localparam logic [W-1:0] SYNC_WORD = 10'b0011111010;
  localparam int SYNC_PERIOD = 16;
  localparam int LOCK_CNT    = 4;
  localparam int LOSS_CNT    = 3;
  localparam int SLIP_WAIT   = 4;
  localparam int POS_W       = $clog2(SYNC_PERIOD);
  localparam int HIT_W       = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W      = $clog2(LOSS_CNT + 1);
  localparam int WAIT_W      = $clog2(SLIP_WAIT + 1);
  typedef enum logic [2:0] {HUNT, SLIP, WAIT, VERIFY, LOCKED} state_t;
endpackage

// File: rtl/rx_word_aligner_if.sv
// rx_word_aligner_if: deserializer word stream in, aligned payload and lock status out
interface rx_word_aligner_if;
  import rx_align_pkg::*;
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic         pol_inv;
  logic         bitslip;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         locked;
  logic         inv_phase;
  logic [3:0]   slip_count;
  logic [7:0]   err_count;
  modport master (output rx_word, rx_valid, pol_inv,
                  input bitslip, data_out, data_valid, locked, inv_phase, slip_count, err_count);
  modport slave  (input rx_word, rx_valid, pol_inv,
                  output bitslip, data_out, data_valid, locked, inv_phase, slip_count, err_count);
endinterface

// File: rtl/rx_sync_detect.sv
// rx_sync_detect: de-inverts a raw word and flags true or inverted sync word matches
module rx_sync_detect
  import rx_align_pkg::*;
(
  input  logic [W-1:0] rx_word,
  input  logic         ph,
  input  logic         pol_inv,
  output logic [W-1:0] corr,
  output logic         pos_match,
  output logic         neg_match
);
  assign corr      = rx_word ^ {W{ph ^ pol_inv}};
  assign pos_match = corr == SYNC_WORD;
  assign neg_match = corr == ~SYNC_WORD;
endmodule

// File: rtl/rx_word_aligner.sv
// rx_word_aligner: bitslip/phase/frame-lock controller; define RX_ALIGN_ERRCNT_EN to build err_count
module rx_word_aligner
  import rx_align_pkg::*;
(
  input logic              RCLK,
  input logic              rst_n,
  rx_word_aligner_if.slave bus
);
  state_t              state;
  logic                ph, pos_m, neg_m, sync_slot;
  logic [W-1:0]        corr;
  logic [POS_W-1:0]    pos, miss, nxt_pos;
  logic [HIT_W-1:0]    hits;
  logic [LOSS_W-1:0]   loss;
  logic [WAIT_W-1:0]   wcnt;
  rx_sync_detect u_det (
    .rx_word   (bus.rx_word),
    .ph        (ph),
    .pol_inv   (bus.pol_inv),
    .corr      (corr),
    .pos_match (pos_m),
    .neg_match (neg_m)
  );
  // pos holds the slot of the previous word; nxt_pos is the slot of the word now on rx_word
  assign nxt_pos     = (pos == POS_W'(SYNC_PERIOD - 1)) ? '0 : pos + 1'b1;
  assign sync_slot   = nxt_pos == '0;
  assign bus.inv_phase = ph;
  always_ff @(posedge RCLK or negedge rst_n)
    if (!rst_n) begin
      state          <= HUNT;
      ph             <= 1'b0;
      pos            <= '0;
      miss           <= '0;
      hits           <= '0;
      loss           <= '0;
      wcnt           <= '0;
      bus.bitslip    <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.locked     <= 1'b0;
      bus.slip_count <= '0;
    end else begin
      bus.bitslip    <= 1'b0;
      bus.data_valid <= 1'b0;
      if (bus.rx_valid) ph <= ~ph;
      case (state)
        HUNT: if (bus.rx_valid) begin
          if (pos_m || neg_m) begin
            state <= VERIFY;
            hits  <= HIT_W'(1);
            pos   <= '0;
            miss  <= '0;
            // an inverted sync means our phase is off by one word: skip this toggle
            if (neg_m) ph <= ph;
          end else if (miss == POS_W'(SYNC_PERIOD - 1)) begin
            state       <= SLIP;
            bus.bitslip <= 1'b1;
            miss        <= '0;
          end else miss <= miss + 1'b1;
        end
        SLIP: begin
          state          <= WAIT;
          bus.slip_count <= (bus.slip_count == 4'(W - 1)) ? '0 : bus.slip_count + 1'b1;
        end
        WAIT: if (bus.rx_valid) begin
          if (wcnt == WAIT_W'(SLIP_WAIT - 1)) begin
            state <= HUNT;
            wcnt  <= '0;
          end else wcnt <= wcnt + 1'b1;
        end
        VERIFY: if (bus.rx_valid) begin
          pos <= nxt_pos;
          if (sync_slot && pos_m) begin
            if (hits == HIT_W'(LOCK_CNT - 1)) begin
              state          <= LOCKED;
              bus.locked     <= 1'b1;
              bus.slip_count <= '0;
              loss           <= '0;
            end else hits <= hits + 1'b1;
          end else if (sync_slot) begin
            state       <= SLIP;
            bus.bitslip <= 1'b1;
          end
        end
        LOCKED: if (bus.rx_valid) begin
          pos <= nxt_pos;
          if (!sync_slot) begin
            bus.data_out   <= corr;
            bus.data_valid <= 1'b1;
          end else if (pos_m) loss <= '0;
          else if (loss == LOSS_W'(LOSS_CNT - 1)) begin
            state      <= HUNT;
            bus.locked <= 1'b0;
            miss       <= '0;
            loss       <= '0;
          end else loss <= loss + 1'b1;
        end
        default: state <= HUNT;
      endcase
    end
`ifdef RX_ALIGN_ERRCNT_EN
  logic sync_miss;
  assign sync_miss = state == LOCKED && bus.rx_valid && sync_slot && !pos_m;
  always_ff @(posedge RCLK or negedge rst_n)
    if (!rst_n) bus.err_count <= '0;
    else if (sync_miss && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 1'b1;
`else
  assign bus.err_count = '0;
`endif
endmodule
